cms_ctrl_sequencer: RTL

- Queues control writes from a host-side valid/ready port.
- Replays each write onto the continuous monitoring system's ctrl_addr / ctrl_wdata / ctrl_write_enable bus as a clean setup → strobe → gap sequence.
- The CMS write enable is posedge-triggered, so back-to-back host writes must never merge into one long high level. This block guarantees a deasserted gap between strobes.
- Sits between the processor-side register/GPIO bridge and the CMS control inputs.

---
 rtl/cms_ctrl_sequencer.sv | 113 +++++++++++
 1 files changed

// File: rtl/cms_ctrl_sequencer.sv
// cms_ctrl_sequencer: queues host control writes and replays each as setup/strobe/gap on the CMS bus
module cms_ctrl_sequencer #(
  parameter int ADDR_WIDTH    = 8,
  parameter int DATA_WIDTH    = 64,
  parameter int FIFO_DEPTH    = 4,
  parameter int STROBE_CYCLES = 1,
  parameter int GAP_CYCLES    = 1,
  parameter int COUNT_WIDTH   = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic [ADDR_WIDTH-1:0]          cmd_addr,
  input  logic [DATA_WIDTH-1:0]          cmd_wdata,
  input  logic                           pause,
  input  logic                           flush,
  output logic [ADDR_WIDTH-1:0]          ctrl_addr,
  output logic [DATA_WIDTH-1:0]          ctrl_wdata,
  output logic                           ctrl_write_enable,
  output logic                           busy,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
  output logic [COUNT_WIDTH-1:0]         issued_count
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int TW = $clog2((STROBE_CYCLES > GAP_CYCLES ? STROBE_CYCLES : GAP_CYCLES) + 1);
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, GAP} state_e;
  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   mem_addr [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]   mem_data [FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]           level_q, level_d;
  logic [TW-1:0]           tmr_q, tmr_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    en_q, en_d;
  logic [COUNT_WIDTH-1:0]  count_q, count_d;
  logic                    push, pop;
  assign cmd_ready         = level_q < LW'(FIFO_DEPTH);
  assign push              = cmd_valid && cmd_ready && !flush;
  assign pop               = state_q == IDLE && level_q != '0 && !pause;
  assign ctrl_addr         = addr_q;
  assign ctrl_wdata        = data_q;
  assign ctrl_write_enable = en_q;
  assign busy              = state_q != IDLE || level_q != '0;
  assign fifo_level        = level_q;
  assign issued_count      = count_q;
  // flush clears the queue but a same-cycle pop still hands its entry to the FSM
  always_comb begin
    wr_ptr_d = flush ? '0 : wr_ptr_q + PW'(push);
    rd_ptr_d = flush ? '0 : rd_ptr_q + PW'(pop);
    level_d  = flush ? '0 : level_q + LW'(push) - LW'(pop);
  end
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    count_d = count_q;
    case (state_q)
      IDLE: if (pop) begin
        state_d = SETUP;
        addr_d  = mem_addr[rd_ptr_q];
        data_d  = mem_data[rd_ptr_q];
      end
      SETUP: begin
        state_d = STROBE;
        tmr_d   = '0;
        count_d = count_q + COUNT_WIDTH'(1);
      end
      STROBE: begin
        state_d = tmr_q == TW'(STROBE_CYCLES - 1) ? GAP : STROBE;
        tmr_d   = tmr_q == TW'(STROBE_CYCLES - 1) ? '0 : tmr_q + TW'(1);
      end
      GAP: begin
        state_d = tmr_q == TW'(GAP_CYCLES - 1) ? IDLE : GAP;
        tmr_d   = tmr_q == TW'(GAP_CYCLES - 1) ? '0 : tmr_q + TW'(1);
      end
    endcase
    en_d = state_d == STROBE;
  end
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr_q] <= cmd_addr;
      mem_data[wr_ptr_q] <= cmd_wdata;
    end
  end
  // enable is a flop so the strobe is glitch-free and drops the instant reset asserts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      tmr_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      en_q     <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      tmr_q    <= tmr_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      en_q     <= en_d;
      count_q  <= count_d;
    end
  end
endmodule
